// File: rtl/sdr_arbiter_if.sv
// Signal bundle between the SDRAM scheduler and the write/read/refresh engines.
// The scheduler sits on the slave modport; the engines and clients sit on the master modport.
`timescale 1ns/1ps
interface sdr_arbiter_if;
  // Handshake rules: *_pend and *_pausing are levels that the arbiter samples each cycle.
  // *_req are one-cycle start pulses from the arbiter. *_exit and ref_done are one-cycle
  // pulses from the engines, honoured only while the arbiter is in the matching state.
  logic       init_done;
  logic       wr_pend;
  logic       rd_pend;
  logic       wr_req;
  logic       wr_exit;
  logic       wr_pausing;
  logic       rd_req;
  logic       rd_exit;
  logic       rd_pausing;
  logic       ref_req;
  logic       ref_done;
  logic       need_ref;
  logic       ref_late;
  logic [1:0] bus_sel;
  logic       busy;

  modport slave (
    input  init_done, wr_pend, rd_pend, wr_exit, wr_pausing,
           rd_exit, rd_pausing, ref_done,
    output wr_req, rd_req, ref_req, need_ref, ref_late, bus_sel, busy
  );

  modport master (
    output init_done, wr_pend, rd_pend, wr_exit, wr_pausing,
           rd_exit, rd_pausing, ref_done,
    input  wr_req, rd_req, ref_req, need_ref, ref_late, bus_sel, busy
  );
endinterface

// File: rtl/sdr_arbiter.sv
// SDRAM scheduler: owns the refresh-interval timer and grants the command bus to the
// write, read or refresh engine, parking an in-flight transfer around a refresh.
`timescale 1ns/1ps
module sdr_arbiter #(
  parameter int unsigned REF_INTERVAL = 1300,
  parameter int unsigned REF_CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  sdr_arbiter_if.slave sdr,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_REFRESH = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_WR   = 2'd1,
    RES_RD   = 2'd2
  } resume_e;

  localparam logic [REF_CNT_W-1:0] CNT_LAST = REF_CNT_W'(REF_INTERVAL - 1);

  state_e               state_q, state_d;
  resume_e              resume_q, resume_d;
  logic                 last_rd_q, last_rd_d;
  logic [REF_CNT_W-1:0] cnt_q, cnt_d;
  logic                 need_ref_q, need_ref_d;
  logic                 ref_late_q, ref_late_d;
  logic                 wr_req_q, wr_req_d;
  logic                 rd_req_q, rd_req_d;
  logic                 ref_req_q, ref_req_d;
  logic [1:0]           bus_sel_q, bus_sel_d;
  logic                 busy_q, busy_d;
  logic                 running;
  logic                 wrap;

  always_comb begin
    running = (state_q != ST_INIT);
    wrap    = running && (cnt_q == CNT_LAST);
    cnt_d   = cnt_q;
    if (running) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    state_d   = state_q;
    resume_d  = resume_q;
    last_rd_d = last_rd_q;

    case (state_q)
      ST_INIT: begin
        if (sdr.init_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // A wrap this cycle raises need_ref on the same edge, so no grant may go out with it.
        if (need_ref_q) begin
          state_d  = ST_REFRESH;
          resume_d = RES_NONE;
        end else if (!wrap) begin
          if (sdr.wr_pend && sdr.rd_pend) begin
            state_d   = last_rd_q ? ST_WRITE : ST_READ;
            last_rd_d = !last_rd_q;
          end else if (sdr.wr_pend) begin
            state_d   = ST_WRITE;
            last_rd_d = 1'b0;
          end else if (sdr.rd_pend) begin
            state_d   = ST_READ;
            last_rd_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (sdr.wr_exit && need_ref_q) begin
          state_d  = ST_REFRESH;
          resume_d = RES_NONE;
        end else if (sdr.wr_exit) begin
          state_d = ST_IDLE;
        end else if (sdr.wr_pausing && need_ref_q) begin
          state_d  = ST_REFRESH;
          resume_d = RES_WR;
        end
      end
      ST_READ: begin
        if (sdr.rd_exit && need_ref_q) begin
          state_d  = ST_REFRESH;
          resume_d = RES_NONE;
        end else if (sdr.rd_exit) begin
          state_d = ST_IDLE;
        end else if (sdr.rd_pausing && need_ref_q) begin
          state_d  = ST_REFRESH;
          resume_d = RES_RD;
        end
      end
      ST_REFRESH: begin
        if (sdr.ref_done) begin
          case (resume_q)
            RES_WR:  state_d = ST_WRITE;
            RES_RD:  state_d = ST_READ;
            default: state_d = ST_IDLE;
          endcase
          resume_d = RES_NONE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // A wrap coinciding with ref_done leaves a refresh still owed.
    need_ref_d = need_ref_q;
    if (wrap) begin
      need_ref_d = 1'b1;
    end else if ((state_q == ST_REFRESH) && sdr.ref_done) begin
      need_ref_d = 1'b0;
    end
    ref_late_d = ref_late_q | (wrap & need_ref_q);

    // Resumed transfers re-enter from REFRESH, so only an IDLE entry pulses the engine.
    wr_req_d  = (state_q == ST_IDLE) && (state_d == ST_WRITE);
    rd_req_d  = (state_q == ST_IDLE) && (state_d == ST_READ);
    ref_req_d = (state_q != ST_REFRESH) && (state_d == ST_REFRESH);

    case (state_d)
      ST_WRITE:   bus_sel_d = 2'd1;
      ST_READ:    bus_sel_d = 2'd2;
      ST_REFRESH: bus_sel_d = 2'd3;
      default:    bus_sel_d = 2'd0;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_INIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      resume_q   <= RES_NONE;
      last_rd_q  <= 1'b1;
      cnt_q      <= '0;
      need_ref_q <= 1'b0;
      ref_late_q <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      ref_req_q  <= 1'b0;
      bus_sel_q  <= 2'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      last_rd_q  <= last_rd_d;
      cnt_q      <= cnt_d;
      need_ref_q <= need_ref_d;
      ref_late_q <= ref_late_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      ref_req_q  <= ref_req_d;
      bus_sel_q  <= bus_sel_d;
      busy_q     <= busy_d;
    end
  end

  assign sdr.wr_req   = wr_req_q;
  assign sdr.rd_req   = rd_req_q;
  assign sdr.ref_req  = ref_req_q;
  assign sdr.need_ref = need_ref_q;
  assign sdr.ref_late = ref_late_q;
  assign sdr.bus_sel  = bus_sel_q;
  assign sdr.busy     = busy_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sdr_arbiter.sv
// Directed bench for sdr_arbiter: start pulses are checked against a cycle-stamped expected
// queue by a monitor; level outputs are checked inline at hand-computed cycles.
`timescale 1ns/1ps
module tb_sdr_arbiter;
  localparam int REF_INT = 50;
  localparam int W       = 21;
  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_RD  = 2'd2;
  localparam logic [1:0] K_REF = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         t0 = 0;
  logic [W-1:0] exp_q[$];

  sdr_arbiter_if bus_if();

  sdr_arbiter #(.REF_INTERVAL(REF_INT), .REF_CNT_W(16)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .sdr         (bus_if),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ev(input int c, input logic [1:0] kind,
                                      input logic [1:0] bus, input logic need);
    logic [31:0] cv;
    cv = c;
    return {cv[15:0], kind, bus, need};
  endfunction

  task automatic expect_ev(input int c, input logic [1:0] kind, input logic [1:0] bus,
                           input logic need);
    exp_q.push_back(ev(c, kind, bus, need));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: cycle %0d got %0h, required %0h", name, cyc, act, want);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int target);
    if (cyc > target) begin
      chk("schedule", cyc, target);
    end else if (cyc < target) begin
      tick(target - cyc);
    end
  endtask

  task automatic pulse_in(input int which);
    case (which)
      0: bus_if.wr_exit  = 1'b1;
      1: bus_if.rd_exit  = 1'b1;
      default: bus_if.ref_done = 1'b1;
    endcase
    tick(1);
    bus_if.wr_exit  = 1'b0;
    bus_if.rd_exit  = 1'b0;
    bus_if.ref_done = 1'b0;
  endtask

  task automatic outputs_zero(input string name);
    chk(name, {25'd0, bus_if.wr_req, bus_if.rd_req, bus_if.ref_req, bus_if.need_ref,
               bus_if.ref_late, bus_if.busy, bus_if.bus_sel != 2'd0}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.init_done  = 1'b0;
    bus_if.wr_pend    = 1'b0;
    bus_if.rd_pend    = 1'b0;
    bus_if.wr_exit    = 1'b0;
    bus_if.wr_pausing = 1'b0;
    bus_if.rd_exit    = 1'b0;
    bus_if.rd_pausing = 1'b0;
    bus_if.ref_done   = 1'b0;
    tick(1);
    outputs_zero("reset_outputs");
    rst = 1'b0;
    tick(2);
    chk("init_hold_busy", bus_if.busy, 0);
    bus_if.init_done = 1'b1;
    tick(1);
    t0 = cyc;
    bus_if.init_done = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [1:0]   kind;
    logic [W-1:0] act;
    logic [W-1:0] want;
    if (!rst && (bus_if.wr_req === 1'b1 || bus_if.rd_req === 1'b1 || bus_if.ref_req === 1'b1)) begin
      case ({bus_if.wr_req, bus_if.rd_req, bus_if.ref_req})
        3'b100:  kind = K_WR;
        3'b010:  kind = K_RD;
        3'b001:  kind = K_REF;
        default: kind = 2'd0;
      endcase
      act = ev(cyc, kind, bus_if.bus_sel, bus_if.need_ref);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected: cycle %0d kind %0d bus %0d, none required",
                 cyc, kind, bus_if.bus_sel);
      end else begin
        want = exp_q.pop_front();
        if (act !== want) begin
          bad++;
          $display("FAIL grant: got cyc=%0d kind=%0d bus=%0d need=%0b, required cyc=%0d kind=%0d bus=%0d need=%0b",
                   act[20:5], act[4:3], act[2:1], act[0], want[20:5], want[4:3], want[2:1], want[0]);
        end
      end
    end
  end

  initial begin
    // tie between write and read, then an exit colliding with need_ref
    do_reset();
    bus_if.wr_pend = 1'b1;
    bus_if.rd_pend = 1'b1;
    expect_ev(t0 + 1, K_WR, 2'd1, 1'b0);
    goto(t0 + 20);
    chk("tie_bus_wr", bus_if.bus_sel, 1);
    pulse_in(0);
    chk("tie_bus_idle1", bus_if.bus_sel, 0);
    expect_ev(t0 + 22, K_RD, 2'd2, 1'b0);
    goto(t0 + 41);
    chk("tie_bus_rd", bus_if.bus_sel, 2);
    pulse_in(1);
    chk("tie_bus_idle2", bus_if.bus_sel, 0);
    expect_ev(t0 + 43, K_WR, 2'd1, 1'b0);
    goto(t0 + 44);
    chk("tie_bus_wr2", bus_if.bus_sel, 1);
    goto(t0 + 50);
    chk("tie_need_ref", bus_if.need_ref, 1);
    bus_if.wr_pend = 1'b0;
    bus_if.rd_pend = 1'b0;
    expect_ev(t0 + 63, K_REF, 2'd3, 1'b1);
    goto(t0 + 62);
    pulse_in(0);
    chk("collide_bus_ref", bus_if.bus_sel, 3);
    goto(t0 + 72);
    pulse_in(2);
    chk("collide_idle", {bus_if.need_ref, bus_if.busy, bus_if.bus_sel}, 0);
    goto(t0 + 80);

    // refresh from idle, with stray pulses ignored while refreshing
    do_reset();
    expect_ev(t0 + 51, K_REF, 2'd3, 1'b1);
    goto(t0 + 49);
    chk("idle_need_ref_pre", bus_if.need_ref, 0);
    tick(1);
    chk("idle_need_ref_rise", {bus_if.need_ref, bus_if.bus_sel}, {29'd0, 1'b1, 2'd0});
    tick(1);
    chk("idle_ref_bus", {bus_if.busy, bus_if.bus_sel}, {29'd0, 1'b1, 2'd3});
    pulse_in(0);
    pulse_in(1);
    chk("idle_stray_exit", bus_if.bus_sel, 3);
    goto(t0 + 60);
    pulse_in(2);
    chk("idle_ref_done", {bus_if.need_ref, bus_if.busy, bus_if.bus_sel}, 0);
    goto(t0 + 66);

    // refresh while the write engine parks, then a resume without a new wr_req
    do_reset();
    bus_if.wr_pend = 1'b1;
    expect_ev(t0 + 1, K_WR, 2'd1, 1'b0);
    tick(1);
    bus_if.wr_pend = 1'b0;
    goto(t0 + 52);
    chk("pause_need_ref", bus_if.need_ref, 1);
    bus_if.wr_pausing = 1'b1;
    expect_ev(t0 + 53, K_REF, 2'd3, 1'b1);
    tick(1);
    chk("pause_bus_ref", bus_if.bus_sel, 3);
    goto(t0 + 62);
    pulse_in(2);
    chk("resume_write", {bus_if.need_ref, bus_if.busy, bus_if.bus_sel}, {29'd0, 1'b0, 1'b1, 2'd1});
    bus_if.wr_pausing = 1'b0;
    goto(t0 + 70);
    pulse_in(0);
    chk("resume_exit_idle", bus_if.bus_sel, 0);
    bus_if.wr_pend = 1'b1;
    bus_if.rd_pend = 1'b1;
    expect_ev(t0 + 72, K_RD, 2'd2, 1'b0);
    tick(1);
    bus_if.wr_pend = 1'b0;
    chk("tie_after_resume", bus_if.bus_sel, 2);

    // reset in the middle of a read
    goto(t0 + 75);
    rst = 1'b1;
    tick(1);
    outputs_zero("reset_mid_read");
    rst = 1'b0;
    tick(4);
    chk("no_grant_before_init", {bus_if.busy, bus_if.bus_sel}, 0);
    bus_if.init_done = 1'b1;
    tick(1);
    t0 = cyc;
    expect_ev(t0 + 1, K_RD, 2'd2, 1'b0);
    tick(1);
    bus_if.rd_pend = 1'b0;
    chk("grant_after_init", bus_if.bus_sel, 2);
    goto(t0 + 5);
    pulse_in(1);

    // late refresh: second wrap while still owed, coinciding with ref_done
    do_reset();
    expect_ev(t0 + 51, K_REF, 2'd3, 1'b1);
    goto(t0 + 99);
    chk("late_pre", {bus_if.ref_late, bus_if.bus_sel}, {29'd0, 1'b0, 2'd3});
    bus_if.ref_done = 1'b1;
    expect_ev(t0 + 101, K_REF, 2'd3, 1'b1);
    tick(1);
    bus_if.ref_done = 1'b0;
    chk("late_set", {bus_if.ref_late, bus_if.need_ref, bus_if.bus_sel}, {29'd0, 1'b1, 1'b1, 2'd0});
    tick(1);
    chk("late_rerefresh_bus", bus_if.bus_sel, 3);
    goto(t0 + 104);
    pulse_in(2);
    chk("late_sticky", {bus_if.ref_late, bus_if.need_ref, bus_if.bus_sel}, {29'd0, 1'b1, 1'b0, 2'd0});
    tick(3);
    do_reset();
    tick(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
